// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light sequencer.
//   state_t    : sequencer states
//   lfsr_taps  : Galois feedback mask giving a maximal-length sequence for a
//                register of the given width (2..16); bit i set means tap i+1.
package f1_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HOLD,
    S_GO,
    S_DONE,
    S_FAULT
  } state_t;

  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Free-running Galois LFSR used to pick the random hold time.
//   clk : clock, rising edge
//   rst : synchronous active-low reset, loads 1
//   q   : current LFSR state, never zero
module lfsr_prng
  import f1_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  always_ff @(posedge clk) begin
    if (!rst) q <= WIDTH'(1);
    else      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
  end

endmodule

// File: rtl/f1_race_start.sv
// F1 race start sequencer: lights fill one per prescaler tick, hold for a
// random number of ticks, go out, then the driver's reaction time is counted.
//   clk, rst    : clock and synchronous active-low reset
//   en_timer, N : prescaler enable and reload (tick every N+1 enabled cycles)
//   trigger     : start request (ignored while busy)
//   react       : driver button
//   led_num     : lights, bit 0 first
//   busy        : sequence in progress (FILL/HOLD/GO)
//   rt_valid    : rt_count holds a reaction time
//   rt_count    : cycles from lights-out to react, saturating
//   jump_start  : react seen before lights-out
module f1_race_start
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = 8,
  parameter int WIDTH      = 16,
  parameter int LFSR_WIDTH = 7,
  parameter int RT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_timer,
  input  logic [WIDTH-1:0]      N,
  input  logic                  trigger,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] led_num,
  output logic                  busy,
  output logic                  rt_valid,
  output logic [RT_WIDTH-1:0]   rt_count,
  output logic                  jump_start
);

  state_t                state;
  logic [WIDTH-1:0]      pcnt;
  logic [LFSR_WIDTH-1:0] hold_cnt;
  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic                  tick;
  logic                  accept;

  lfsr_prng #(.WIDTH(LFSR_WIDTH)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  always_comb begin
    tick   = en_timer && (pcnt == '0);
    accept = trigger && (state == S_IDLE || state == S_DONE || state == S_FAULT);
  end

  // Prescaler restarts from N on an accepted trigger so the first light
  // always appears N+1 enabled cycles after the start request.
  always_ff @(posedge clk) begin
    if (!rst)             pcnt <= N;
    else if (accept)      pcnt <= N;
    else if (en_timer)    pcnt <= (pcnt == '0) ? N : pcnt - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      led_num    <= '0;
      busy       <= 1'b0;
      rt_valid   <= 1'b0;
      rt_count   <= '0;
      jump_start <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (trigger) begin
            state      <= S_FILL;
            busy       <= 1'b1;
            led_num    <= '0;
            rt_valid   <= 1'b0;
            jump_start <= 1'b0;
          end
        end
        S_FILL, S_HOLD: begin
          // A button press before lights-out wins over a same-cycle tick.
          if (react) begin
            state      <= S_FAULT;
            busy       <= 1'b0;
            jump_start <= 1'b1;
            led_num    <= '0;
          end else if (tick) begin
            if (state == S_FILL) begin
              if (&led_num) begin
                state    <= S_HOLD;
                hold_cnt <= lfsr_q;
              end else begin
                led_num <= {led_num[NUM_LIGHTS-2:0], 1'b1};
              end
            end else begin
              if (hold_cnt == LFSR_WIDTH'(1)) begin
                state    <= S_GO;
                led_num  <= '0;
                rt_count <= '0;
              end else begin
                hold_cnt <= hold_cnt - LFSR_WIDTH'(1);
              end
            end
          end
        end
        S_GO: begin
          if (react) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            rt_valid <= 1'b1;
          end else if (rt_count != '1) begin
            rt_count <= rt_count + RT_WIDTH'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/f1_race_start.md
F1_RACE_START -- requirements
Module: f1_race_start

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 8: number of start lights (2..16).
REQ-002 SHALL have parameter WIDTH, default 16: prescaler reload width.
REQ-003 SHALL have parameter LFSR_WIDTH, default 7: random-hold generator width.
REQ-004 SHALL have parameter RT_WIDTH, default 16: reaction-time counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port en_timer  in  1  prescaler enable.
REQ-008 SHALL have port N  in  WIDTH  prescaler reload; tick period is N+1 enabled cycles.
REQ-009 SHALL have port trigger  in  1  start request, level-sampled each cycle.
REQ-010 SHALL have port react  in  1  driver button, level-sampled each cycle.
REQ-011 SHALL have port led_num  out  NUM_LIGHTS  light outputs, bit 0 = first light.
REQ-012 SHALL have port busy  out  1  high in FILL, HOLD and GO.
REQ-013 SHALL have port rt_valid  out  1  reaction time valid.
REQ-014 SHALL have port rt_count  out  RT_WIDTH  clk cycles from lights-out to react.
REQ-015 SHALL have port jump_start  out  1  react seen before lights-out.

Function
REQ-016 Prescaler: down-counter reloads N when it reaches 0 with en_timer high, producing a 1-cycle tick that cycle; it holds while en_timer is low; N=0 gives a tick on every enabled cycle.
REQ-017 States SHALL be IDLE, FILL, HOLD, GO, DONE, FAULT.
REQ-018 IDLE/DONE/FAULT + trigger -> FILL; led_num<=0, prescaler counter<=N, rt_valid<=0, jump_start<=0.
REQ-019 FILL: each tick SHALL update led_num<={led_num[NUM_LIGHTS-2:0],1'b1}; a tick with led_num all ones -> HOLD, hold_cnt<=current LFSR value.
REQ-020 HOLD: each tick decrements hold_cnt; a tick with hold_cnt==1 -> GO, led_num<=0, rt_count<=0.
REQ-021 GO: rt_count SHALL increment each clk cycle without react, saturating at all-ones; react -> DONE, rt_valid<=1, rt_count frozen.
REQ-022 react in FILL or HOLD SHALL -> FAULT, jump_start<=1, led_num<=0; react takes priority over a same-cycle tick.
REQ-023 trigger SHALL be ignored while busy; react SHALL be ignored in IDLE, DONE and FAULT.
REQ-024 LFSR: Galois, maximal-length taps for LFSR_WIDTH, advances every clk cycle regardless of state, never zero, so the hold is 1..2^LFSR_WIDTH-1 ticks.
REQ-025 rt_valid, rt_count and jump_start SHALL hold their values until the next accepted trigger.
REQ-026 Outputs SHALL be registered; led_num changes on the clock edge after the qualifying tick.

Reset
REQ-027 rst low at a clk edge SHALL force IDLE, led_num=0, busy=0, rt_valid=0, rt_count=0, jump_start=0, prescaler counter=N, hold_cnt=0, LFSR=1, including mid-sequence.
REQ-028 The first accepted trigger SHALL be the first one sampled with rst high.

Structure
REQ-029 State enum and LFSR tap constants per LFSR_WIDTH SHALL live in package f1_pkg.
REQ-030 The LFSR SHALL be sub-module lfsr_prng (parameter WIDTH, ports clk, rst, q); prescaler and FSM stay in f1_race_start.

Verification (NUM_LIGHTS=8, WIDTH=16, N=3, en_timer=1)
REQ-031 Trigger pulse -> led_num 01,03,07,...,FF one step per 4 cycles; HOLD entered on the 9th tick; busy high from the cycle after trigger.
REQ-032 Force LFSR value 5 at HOLD entry -> led_num goes to 00 exactly 5 ticks (20 cycles) after HOLD entry; react 37 cycles later -> rt_valid=1, rt_count=37.
REQ-033 react while led_num=07 -> FAULT, jump_start=1, led_num=00, busy=0; next trigger clears jump_start.
REQ-034 rst low during HOLD -> next cycle all outputs zero, IDLE; trigger mid-FILL has no effect.
REQ-035 RT_WIDTH=4, no react for 20 cycles in GO -> rt_count saturates at 15; react -> rt_valid=1, rt_count=15.
REQ-036 en_timer low for 10 cycles during FILL -> led_num frozen, sequence resumes with no tick lost or added.
